// File: rtl/reg_stack_if.sv
// Bus between the UL8 control unit (master) and the register stack (slave).
// push/pop/clr_err are one-cycle request strobes sampled on the rising clk edge.
interface reg_stack_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    // Handshake: there is no ready; the stack accepts every request on the edge
    // it is sampled. Requests that cannot be honoured are dropped and recorded
    // in the sticky overflow/underflow flags instead of being stalled.
    logic [WIDTH-1:0] data_in;
    logic             push;
    logic             pop;
    logic             clr_err;
    logic [WIDTH-1:0] data_out;
    logic [CNT_W-1:0] count;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             underflow;

    modport master (
        output data_in, push, pop, clr_err,
        input  data_out, count, empty, full, overflow, underflow
    );

    modport slave (
        input  data_in, push, pop, clr_err,
        output data_out, count, empty, full, overflow, underflow
    );
endinterface

// File: rtl/reg_stack.sv
// LIFO register stack for the UL8 CPU: CALL/RET return addresses and PUSH/POP data.
// The control state (EMPTY/PARTIAL/FULL) is a decode of the entry count.
module reg_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int CNT_W = 4
) (
    input  logic       clk,
    input  logic       resetn,
    reg_stack_if.slave bus,
    output logic [1:0] dbg_state
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [1:0] ST_EMPTY   = 2'd0;
    localparam logic [1:0] ST_PARTIAL = 2'd1;
    localparam logic [1:0] ST_FULL    = 2'd2;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic [WIDTH-1:0] mem_wdata;
    logic [CNT_W-1:0] top_idx;
    logic [1:0]       state;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q    <= '0;
            data_out_q <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            count_q    <= count_d;
            data_out_q <= data_out_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    // Storage is deliberately left out of reset; only count defines validity.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign top_idx = count_q - CNT_W'(1);

    always_comb begin
        count_d    = count_q;
        data_out_d = data_out_q;
        ovf_d      = bus.clr_err ? 1'b0 : ovf_q;
        unf_d      = bus.clr_err ? 1'b0 : unf_q;
        mem_we     = 1'b0;
        mem_waddr  = count_q[AW-1:0];
        mem_wdata  = bus.data_in;
        case ({bus.push, bus.pop})
            2'b10: begin
                if (state == ST_FULL) begin
                    ovf_d = 1'b1;
                end else begin
                    mem_we  = 1'b1;
                    count_d = count_q + CNT_W'(1);
                end
            end
            2'b01: begin
                if (state == ST_EMPTY) begin
                    unf_d = 1'b1;
                end else begin
                    data_out_d = mem_q[top_idx[AW-1:0]];
                    count_d    = top_idx;
                end
            end
            2'b11: begin
                // Swap the top entry; on an empty stack the word passes straight through.
                if (state == ST_EMPTY) begin
                    data_out_d = bus.data_in;
                end else begin
                    data_out_d = mem_q[top_idx[AW-1:0]];
                    mem_we     = 1'b1;
                    mem_waddr  = top_idx[AW-1:0];
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state = ST_PARTIAL;
        if (count_q == '0) begin
            state = ST_EMPTY;
        end else if (count_q == CNT_FULL) begin
            state = ST_FULL;
        end
    end

    assign bus.data_out  = data_out_q;
    assign bus.count     = count_q;
    assign bus.empty     = (state == ST_EMPTY);
    assign bus.full      = (state == ST_FULL);
    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;
    assign dbg_state     = state;
endmodule

// File: tb/tb_reg_stack.sv
// Bench for reg_stack: directed vector table, hand-written reset sequences,
// and randomized traffic against a queue-based LIFO model.
module tb_reg_stack;
    localparam int W     = 8;
    localparam int DEPTH = 8;
    localparam int CNT_W = 4;

    typedef struct {
        logic         push;
        logic         pop;
        logic         clr;
        logic [W-1:0] din;
        logic [W-1:0] dout;
        int           cnt;
        logic         ovf;
        logic         unf;
    } vec_t;

    logic       clk;
    logic       resetn;
    logic [1:0] dbg_state;
    int         n_checks;
    int         n_fail;

    reg_stack_if #(.WIDTH(W), .CNT_W(CNT_W)) bus ();

    reg_stack #(.WIDTH(W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [W-1:0] dout, input int cnt,
                                 input logic ovf, input logic unf);
        logic [1:0] exp_state;
        exp_state = (cnt == 0) ? 2'd0 : ((cnt == DEPTH) ? 2'd2 : 2'd1);
        check({tag, ".data_out"},  bus.data_out,  dout);
        check({tag, ".count"},     bus.count,     cnt);
        check({tag, ".empty"},     bus.empty,     cnt == 0);
        check({tag, ".full"},      bus.full,      cnt == DEPTH);
        check({tag, ".overflow"},  bus.overflow,  ovf);
        check({tag, ".underflow"}, bus.underflow, unf);
        check({tag, ".state"},     dbg_state,     exp_state);
    endtask

    // driver: apply inputs, take one rising edge, settle 1 time unit past it
    task automatic step(input logic p, input logic q, input logic c, input logic [W-1:0] d);
        bus.push    = p;
        bus.pop     = q;
        bus.clr_err = c;
        bus.data_in = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        step(1'b0, 1'b0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b0, '0);
        resetn = 1'b1;
        step(1'b0, 1'b0, 1'b0, '0);
    endtask

    // scoreboard: the model stack and its registered outputs
    logic [W-1:0] exp_q[$];
    logic [W-1:0] dout_m;
    logic         ovf_m;
    logic         unf_m;

    task automatic model_apply(input logic p, input logic q, input logic c, input logic [W-1:0] d);
        if (c) begin
            ovf_m = 1'b0;
            unf_m = 1'b0;
        end
        if (p && !q) begin
            if (exp_q.size() == DEPTH) ovf_m = 1'b1;
            else exp_q.push_back(d);
        end else if (!p && q) begin
            if (exp_q.size() == 0) unf_m = 1'b1;
            else dout_m = exp_q.pop_back();
        end else if (p && q) begin
            if (exp_q.size() == 0) begin
                dout_m = d;
            end else begin
                dout_m = exp_q.pop_back();
                exp_q.push_back(d);
            end
        end
    endtask

    vec_t vecs[$];

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        bus.push    = 1'b0;
        bus.pop     = 1'b0;
        bus.clr_err = 1'b0;
        bus.data_in = '0;
        resetn      = 1'b1;
        #2;

        // reset: held low two cycles then released
        do_reset();
        check_outputs("reset", 8'h00, 0, 1'b0, 1'b0);

        // directed table: {push, pop, clr, din, dout, cnt, ovf, unf}
        vecs.push_back('{1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 0, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 0, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 0, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 8'h11, 8'h00, 1, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 8'h22, 8'h00, 2, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 8'h33, 8'h00, 3, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 8'h00, 8'h33, 2, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 8'h00, 8'h22, 1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 8'h00, 8'h11, 0, 1'b0, 1'b0});
        for (int k = 1; k <= DEPTH; k++) begin
            vecs.push_back('{1'b1, 1'b0, 1'b0, W'(k), 8'h11, k, 1'b0, 1'b0});
        end
        vecs.push_back('{1'b1, 1'b0, 1'b0, 8'hAA, 8'h11, 8, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 8'h99, 8'h08, 8, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 8'h00, 8'h99, 7, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 8'h00, 8'h99, 7, 1'b0, 1'b0});
        for (int k = 7; k >= 1; k--) begin
            vecs.push_back('{1'b0, 1'b1, 1'b0, 8'h00, W'(k), k - 1, 1'b0, 1'b0});
        end
        vecs.push_back('{1'b1, 1'b1, 1'b0, 8'h5C, 8'h5C, 0, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 8'h10, 8'h5C, 1, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 8'h20, 8'h10, 1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 8'h00, 8'h20, 0, 1'b0, 1'b0});

        foreach (vecs[i]) begin
            step(vecs[i].push, vecs[i].pop, vecs[i].clr, vecs[i].din);
            check_outputs($sformatf("vec%0d", i), vecs[i].dout, vecs[i].cnt, vecs[i].ovf, vecs[i].unf);
        end

        // overflow set in the same cycle as clr_err: the new error wins
        for (int k = 0; k < DEPTH; k++) step(1'b1, 1'b0, 1'b0, 8'h40);
        step(1'b1, 1'b0, 1'b1, 8'h41);
        check_outputs("ovf_vs_clr", 8'h20, DEPTH, 1'b1, 1'b0);

        // asynchronous reset between clock edges
        do_reset();
        step(1'b1, 1'b0, 1'b0, 8'hAB);
        step(1'b1, 1'b0, 1'b0, 8'hCD);
        step(1'b0, 1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'hEE);
        bus.push = 1'b0;
        check_outputs("pre_async", 8'hAB, 1, 1'b0, 1'b1);
        #3;
        resetn = 1'b0;
        #1;
        check_outputs("async_rst", 8'h00, 0, 1'b0, 1'b0);
        @(posedge clk);
        #3;
        resetn = 1'b1;
        step(1'b0, 1'b0, 1'b0, '0);
        check_outputs("post_async", 8'h00, 0, 1'b0, 1'b0);

        // randomized traffic: fill-biased half, then drain-biased half
        exp_q.delete();
        dout_m = '0;
        ovf_m  = 1'b0;
        unf_m  = 1'b0;
        for (int i = 0; i < 400; i++) begin
            logic         p;
            logic         q;
            logic         c;
            logic [W-1:0] d;
            p = ($urandom_range(99) < ((i < 200) ? 70 : 30));
            q = ($urandom_range(99) < ((i < 200) ? 35 : 70));
            c = ($urandom_range(99) < 8);
            d = W'($urandom_range(255));
            model_apply(p, q, c, d);
            step(p, q, c, d);
            check_outputs($sformatf("rand%0d", i), dout_m, exp_q.size(), ovf_m, unf_m);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
